// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC (byte offset into instruction memory),
// captures the returned word into IF/ID, and raises sticky misalign/out-of-range flags.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        if_id_valid_o,
    output logic        misalign_o,
    output logic        oob_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;
    logic        r_valid;
    logic        r_misalign;
    logic        r_oob;
    logic [31:0] r_count;

    logic        w_in_range;
    logic [31:0] w_pc_plus4;

    assign w_in_range = (r_pc <= LAST_PC);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc       <= {RESET_PC[31:2], 2'b00};
            r_instr    <= NOP_INSTR;
            r_if_pc    <= 32'd0;
            r_if_pc4   <= 32'd4;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_oob      <= 1'b0;
            r_count    <= 32'd0;
        end else if (redirect_i) begin
            r_pc    <= {redirect_pc_i[31:2], 2'b00};
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else if (stall_i) begin
            if (flush_i) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end else if (flush_i || !w_in_range) begin
            // Bubble into IF/ID; the PC only moves if the current fetch is legal.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            if (w_in_range) begin
                r_pc <= w_pc_plus4;
            end else begin
                r_oob <= 1'b1;
            end
        end else begin
            r_instr  <= instr_i;
            r_if_pc  <= r_pc;
            r_if_pc4 <= w_pc_plus4;
            r_valid  <= 1'b1;
            r_pc     <= w_pc_plus4;
            r_count  <= r_count + 32'd1;
        end
    end

    assign pc_o             = r_pc;
    assign if_id_instr_o    = r_instr;
    assign if_id_pc_o       = r_if_pc;
    assign if_id_pc_plus4_o = r_if_pc4;
    assign if_id_valid_o    = r_valid;
    assign misalign_o       = r_misalign;
    assign oob_o            = r_oob;
    assign fetch_count_o    = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns 32'hC000_0000 | address so
// every captured word identifies the offset it came from.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic        if_id_valid_o;
    logic        misalign_o;
    logic        oob_o;
    logic [31:0] fetch_count_o;

    int n_vec = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .pc_o            (pc_o),
        .instr_i         (instr_i),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_pc_plus4_o(if_id_pc_plus4_o),
        .if_id_valid_o   (if_id_valid_o),
        .misalign_o      (misalign_o),
        .oob_o           (oob_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk_i = ~clk_i;

    assign instr_i = 32'hC000_0000 | pc_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic v);
        chk({tag, ".instr"}, if_id_instr_o, ins);
        chk({tag, ".pc"}, if_id_pc_o, pc);
        chk({tag, ".pc4"}, if_id_pc_plus4_o, pc + 32'd4);
        chk({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, v});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc_o"}, pc_o, 32'h0);
        chk_ifid(tag, NOP, 32'h0, 1'b0);
        chk({tag, ".misalign"}, {31'd0, misalign_o}, 32'd0);
        chk({tag, ".oob"}, {31'd0, oob_o}, 32'd0);
        chk({tag, ".count"}, fetch_count_o, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        step(); step();
        chk_reset("rst");
        rst_i = 1'b0;

        step();
        chk_ifid("f0", 32'hC000_0000, 32'h0, 1'b1);
        chk("f0.pc_o", pc_o, 32'h4);
        step();
        chk_ifid("f1", 32'hC000_0004, 32'h4, 1'b1);
        chk("f1.pc_o", pc_o, 32'h8);
        chk("f1.count", fetch_count_o, 32'd2);

        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall.pc_o", pc_o, 32'h8);
            chk_ifid("stall", 32'hC000_0004, 32'h4, 1'b1);
            chk("stall.count", fetch_count_o, 32'd2);
        end
        stall_i = 1'b0;
        step();
        chk_ifid("f2", 32'hC000_0008, 32'h8, 1'b1);
        chk("f2.count", fetch_count_o, 32'd3);
        chk("f2.pc_o", pc_o, 32'hC);

        redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
        step();
        chk("rdst.pc_o", pc_o, 32'h40);
        chk_ifid("rdst", NOP, 32'h8, 1'b0);
        redirect_i = 1'b0; stall_i = 1'b0;
        step();
        chk_ifid("f40", 32'hC000_0040, 32'h40, 1'b1);
        chk("f40.count", fetch_count_o, 32'd4);

        flush_i = 1'b1;
        step();
        chk_ifid("flush", NOP, 32'h40, 1'b0);
        chk("flush.pc_o", pc_o, 32'h48);
        chk("flush.count", fetch_count_o, 32'd4);
        flush_i = 1'b0;
        step();
        chk_ifid("f48", 32'hC000_0048, 32'h48, 1'b1);
        chk("f48.count", fetch_count_o, 32'd5);

        stall_i = 1'b1; flush_i = 1'b1;
        step();
        chk_ifid("stfl", NOP, 32'h48, 1'b0);
        chk("stfl.pc_o", pc_o, 32'h4C);
        chk("stfl.count", fetch_count_o, 32'd5);
        stall_i = 1'b0; flush_i = 1'b0;

        redirect_i = 1'b1; redirect_pc_i = 32'h22;
        step();
        chk("mis.pc_o", pc_o, 32'h20);
        chk("mis.flag", {31'd0, misalign_o}, 32'd1);
        redirect_pc_i = 32'h100;
        step();
        chk("mis2.pc_o", pc_o, 32'h100);
        chk("mis2.flag", {31'd0, misalign_o}, 32'd1);
        redirect_pc_i = 32'hFF8;
        step();
        chk("rff8.pc_o", pc_o, 32'hFF8);
        redirect_i = 1'b0;

        step();
        chk_ifid("fff8", 32'hC000_0FF8, 32'hFF8, 1'b1);
        chk("fff8.pc_o", pc_o, 32'hFFC);
        step();
        chk_ifid("fffc", 32'hC000_0FFC, 32'hFFC, 1'b1);
        chk("fffc.pc_o", pc_o, 32'h1000);
        chk("fffc.count", fetch_count_o, 32'd7);
        chk("fffc.oob", {31'd0, oob_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk_ifid("oob", NOP, 32'hFFC, 1'b0);
            chk("oob.pc_o", pc_o, 32'h1000);
            chk("oob.flag", {31'd0, oob_o}, 32'd1);
            chk("oob.count", fetch_count_o, 32'd7);
        end

        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        step();
        chk("r0.pc_o", pc_o, 32'h0);
        chk("r0.oob", {31'd0, oob_o}, 32'd1);
        redirect_i = 1'b0;
        step();
        chk_ifid("fr0", 32'hC000_0000, 32'h0, 1'b1);
        chk("fr0.count", fetch_count_o, 32'd8);
        chk("fr0.oob", {31'd0, oob_o}, 32'd1);
        chk("fr0.mis", {31'd0, misalign_o}, 32'd1);

        rst_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h80; stall_i = 1'b1;
        step();
        chk_reset("rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
